// File: rtl/cv32e40p_pkg.sv
// +----------------------------------------------------------------------------+
// | cv32e40p_pkg: ALU operator encoding and EX-stage FSM enums/constants.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cv32e40p_pkg;

  localparam int ALU_OP_WIDTH = 7;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_AND = 7'b0010101,
    ALU_ADD = 7'b0011000,
    ALU_SUB = 7'b0011001,
    ALU_SRA = 7'b0100100,
    ALU_SRL = 7'b0100101,
    ALU_ROR = 7'b0100110,
    ALU_SLL = 7'b0100111,
    ALU_OR  = 7'b0101110,
    ALU_XOR = 7'b0101111
  } alu_opcode_e;

  localparam int SHIFT_AMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_shift_seq_state_e;

  function automatic logic is_shift_op(alu_opcode_e op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROR: is_shift_op = 1'b1;
      default:                            is_shift_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shift_step.sv
// +----------------------------------------------------------------------------+
// | alu_shift_step: one combinational shift/rotate iteration of up to STEP bits.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_shift_step
  import cv32e40p_pkg::*;
#(
  parameter int STEP = 1
) (
  input  alu_opcode_e                     i_op,
  input  logic        [31:0]              i_data,
  input  logic        [$clog2(STEP+1)-1:0] i_amt,
  input  logic                            i_sign,
  output logic        [31:0]              o_data
);

  logic [31:0] w_srl;
  logic [31:0] w_fill_mask;

  // Bits vacated by a right shift, filled with the saved sign for SRA.
  always_comb begin
    w_srl       = i_data >> i_amt;
    w_fill_mask = ~(32'hFFFF_FFFF >> i_amt);
    case (i_op)
      ALU_SLL: o_data = i_data << i_amt;
      ALU_SRL: o_data = w_srl;
      ALU_SRA: o_data = w_srl | (w_fill_mask & {32{i_sign}});
      ALU_ROR: o_data = w_srl | (i_data << (6'd32 - 6'(i_amt)));
      default: o_data = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_shift_seq.sv
// +----------------------------------------------------------------------------+
// | alu_shift_seq: iterative shift/rotate unit, STEP bits per cycle, with      |
// | valid/ready request and result handshakes.  Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_shift_seq
  import cv32e40p_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  alu_opcode_e        operator_i,
  input  logic        [31:0] operand_a_i,
  input  logic        [31:0] operand_b_i,
  output logic               valid_o,
  input  logic               ex_ready_i,
  output logic        [31:0] result_o,
  output logic               illegal_o,
  output logic               busy_o
);

  localparam int                     C_SW   = $clog2(STEP + 1);
  localparam logic [SHIFT_AMT_W-1:0] C_STEP = SHIFT_AMT_W'(STEP);

  alu_shift_seq_state_e   r_state;
  alu_opcode_e            r_op;
  logic [31:0]            r_data;
  logic [SHIFT_AMT_W-1:0] r_cnt;
  logic                   r_sign;
  logic                   r_illegal;

  logic [SHIFT_AMT_W-1:0] w_amt;
  logic [C_SW-1:0]        w_s;
  logic [31:0]            w_step_data;
  logic                   w_legal;
  logic                   w_unused_b;

  assign w_amt      = operand_b_i[SHIFT_AMT_W-1:0];
  assign w_unused_b = ^operand_b_i[31:SHIFT_AMT_W];
  assign w_legal    = is_shift_op(operator_i);
  assign w_s        = (r_cnt < C_STEP) ? r_cnt[C_SW-1:0] : C_STEP[C_SW-1:0];

  alu_shift_step #(
    .STEP (STEP)
  ) u_step (
    .i_op   (r_op),
    .i_data (r_data),
    .i_amt  (w_s),
    .i_sign (r_sign),
    .o_data (w_step_data)
  );

  // Flush wins over both handshakes; the in-flight request is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= ALU_SLL;
      r_data    <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_op      <= operator_i;
            r_data    <= operand_a_i;
            r_cnt     <= w_amt;
            r_sign    <= operand_a_i[31];
            r_illegal <= !w_legal;
            r_state   <= (!w_legal || (w_amt == '0)) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data <= w_step_data;
          r_cnt  <= r_cnt - SHIFT_AMT_W'(w_s);
          if (r_cnt <= C_STEP) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (ex_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o   = (r_state == IDLE);
  assign valid_o   = (r_state == DONE);
  assign busy_o    = (r_state != IDLE);
  assign illegal_o = r_illegal && (r_state == DONE);
  assign result_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_alu_shift_seq.sv
// +----------------------------------------------------------------------------+
// | tb_alu_shift_seq: directed bench for STEP=1 and STEP=4 instances against a  |
// | behavioural latency/result model.  Rev 1.0                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_shift_seq;
  import cv32e40p_pkg::*;

  localparam int STEPS [2] = '{1, 4};

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid1;
  logic        valid4;
  logic        ex_ready;
  alu_opcode_e op_in;
  logic [31:0] opa;
  logic [31:0] opb;

  logic [1:0]  ready_w;
  logic [1:0]  valid_w;
  logic [1:0]  ill_w;
  logic [1:0]  busy_w;
  logic [31:0] res_w [2];

  int total = 0;
  int bad   = 0;

  int          m_phase [2];  // 0 idle, 1 computing, 2 result presented
  int          m_left  [2];
  logic [31:0] m_res   [2];
  logic        m_ill   [2];

  alu_shift_seq #(.STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(valid1), .ready_o(ready_w[0]),
    .operator_i(op_in), .operand_a_i(opa), .operand_b_i(opb), .valid_o(valid_w[0]),
    .ex_ready_i(ex_ready), .result_o(res_w[0]), .illegal_o(ill_w[0]), .busy_o(busy_w[0])
  );

  alu_shift_seq #(.STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(valid4), .ready_o(ready_w[1]),
    .operator_i(op_in), .operand_a_i(opa), .operand_b_i(opb), .valid_o(valid_w[1]),
    .ex_ready_i(ex_ready), .result_o(res_w[1]), .illegal_o(ill_w[1]), .busy_o(busy_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_shift(alu_opcode_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA) || (op == ALU_ROR);
  endfunction

  function automatic int amt_of(logic [31:0] b);
    return int'(b % 32);
  endfunction

  function automatic logic [31:0] exp_res(alu_opcode_e op, logic [31:0] a, int amt);
    case (op)
      ALU_SLL: return a << amt;
      ALU_SRL: return a >> amt;
      ALU_SRA: return 32'($signed(a) >>> amt);
      ALU_ROR: return (a >> amt) | (a << (32 - amt));
      default: return a;
    endcase
  endfunction

  function automatic logic vin(int i);
    return (i == 0) ? valid1 : valid4;
  endfunction

  // Model: result from plain arithmetic, visible after ceil(amt/STEP) busy cycles.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_phase[i] <= 0;
        m_left[i]  <= 0;
      end else if (flush) begin
        m_phase[i] <= 0;
      end else if (m_phase[i] == 0) begin
        if (vin(i)) begin
          m_res[i] <= exp_res(op_in, opa, amt_of(opb));
          m_ill[i] <= !is_shift(op_in);
          if (!is_shift(op_in) || amt_of(opb) == 0) begin
            m_phase[i] <= 2;
          end else begin
            m_phase[i] <= 1;
            m_left[i]  <= (amt_of(opb) + STEPS[i] - 1) / STEPS[i];
          end
        end
      end else if (m_phase[i] == 1) begin
        if (m_left[i] == 1) m_phase[i] <= 2;
        else                m_left[i]  <= m_left[i] - 1;
      end else if (ex_ready) begin
        m_phase[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk((i == 0) ? "ready1" : "ready4", 32'(ready_w[i]), 32'(m_phase[i] == 0));
        chk((i == 0) ? "valid1" : "valid4", 32'(valid_w[i]), 32'(m_phase[i] == 2));
        chk((i == 0) ? "busy1"  : "busy4",  32'(busy_w[i]),  32'(m_phase[i] != 0));
        if (m_phase[i] == 2) begin
          chk((i == 0) ? "result1"  : "result4",  res_w[i], m_res[i]);
          chk((i == 0) ? "illegal1" : "illegal4", 32'(ill_w[i]), 32'(m_ill[i]));
        end
      end
    end
  end

  // Called at #1 after an edge with the target instance idle.
  task automatic issue(int idx, alu_opcode_e op, logic [31:0] a, logic [31:0] b);
    op_in = op;
    opa   = a;
    opb   = b;
    if (idx == 0) valid1 = 1'b1;
    else          valid4 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    valid4 = 1'b0;
  endtask

  task automatic wait_valid(int idx, output int lat);
    lat = 1;
    while (!valid_w[idx] && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(int idx, alu_opcode_e op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] er, int elat, logic eill, string nm);
    int lat;
    issue(idx, op, a, b);
    wait_valid(idx, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_res"}, res_w[idx], er);
    chk({nm, "_ill"}, 32'(ill_w[idx]), 32'(eill));
    @(posedge clk); #1;
    chk({nm, "_rdy"}, 32'(ready_w[idx]), 32'd1);
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_ready"}, 32'(ready_w[0]), 32'd1);
    chk({nm, "_valid"}, 32'(valid_w[0]), 32'd0);
    chk({nm, "_busy"},  32'(busy_w[0]),  32'd0);
    chk({nm, "_ill"},   32'(ill_w[0]),   32'd0);
    chk({nm, "_res"},   res_w[0],        32'd0);
  endtask

  initial begin
    int lat;
    rst_n    = 1'b0;
    flush    = 1'b0;
    valid1   = 1'b0;
    valid4   = 1'b0;
    ex_ready = 1'b1;
    op_in    = ALU_SLL;
    opa      = '0;
    opb      = '0;

    #3;
    chk_reset_vals("rst");
    chk("pin_sra", exp_res(ALU_SRA, 32'h8000_0004, 1), 32'hC000_0002);
    chk("pin_ror", exp_res(ALU_ROR, 32'h0000_0005, 1), 32'h8000_0002);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("post_rst");

    run(0, ALU_SRA, 32'h8000_0004, 32'd1,    32'hC000_0002, 2,  1'b0, "sra");
    run(0, ALU_SRL, 32'h0000_0004, 32'd1,    32'h0000_0002, 2,  1'b0, "srl");
    run(0, ALU_ROR, 32'h0000_0005, 32'd1,    32'h8000_0002, 2,  1'b0, "ror");
    run(0, ALU_SLL, 32'h0000_0005, 32'd2,    32'h0000_0014, 3,  1'b0, "sll");
    run(0, ALU_SLL, 32'h0000_1234, 32'd0,    32'h0000_1234, 1,  1'b0, "amt0");
    run(0, ALU_SLL, 32'h0000_0001, 32'h25,   32'h0000_0020, 6,  1'b0, "amt25");
    run(0, ALU_SRA, 32'h8000_0000, 32'd31,   32'hFFFF_FFFF, 32, 1'b0, "sra31");
    run(1, ALU_SRL, 32'hFFFF_FFFF, 32'd31,   32'h0000_0001, 9,  1'b0, "s4_srl31");
    run(1, ALU_ROR, 32'h1234_5678, 32'd8,    32'h7812_3456, 3,  1'b0, "s4_ror8");
    run(1, ALU_SRA, 32'h8000_0000, 32'd7,    32'hFF00_0000, 3,  1'b0, "s4_sra7");
    run(0, ALU_ADD, 32'h0000_DEAD, 32'd3,    32'h0000_DEAD, 1,  1'b1, "illegal");

    // Backpressure: result must hold while ex_ready is low.
    ex_ready = 1'b0;
    issue(0, ALU_SLL, 32'h0000_0003, 32'd1);
    wait_valid(0, lat);
    chk("bp_lat", 32'(lat), 32'd2);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(valid_w[0]), 32'd1);
      chk("bp_res",   res_w[0],        32'h0000_0006);
      chk("bp_ready", 32'(ready_w[0]), 32'd0);
    end
    ex_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ready", 32'(ready_w[0]), 32'd1);
    chk("bp_rel_valid", 32'(valid_w[0]), 32'd0);

    // Flush on the third busy cycle; a valid presented with it is ignored.
    issue(0, ALU_SLL, 32'h0000_0001, 32'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush  = 1'b1;
    @(posedge clk); #1;
    flush  = 1'b0;
    chk("fl_ready", 32'(ready_w[0]), 32'd1);
    chk("fl_valid", 32'(valid_w[0]), 32'd0);
    chk("fl_busy",  32'(busy_w[0]),  32'd0);
    run(0, ALU_SRL, 32'h0000_0100, 32'd4, 32'h0000_0010, 5, 1'b0, "post_flush");

    op_in  = ALU_SLL;
    opa    = 32'h1;
    opb    = 32'd3;
    valid1 = 1'b1;
    flush  = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    flush  = 1'b0;
    chk("fl_vld_ready", 32'(ready_w[0]), 32'd1);
    chk("fl_vld_busy",  32'(busy_w[0]),  32'd0);

    // Asynchronous reset mid-shift.
    issue(0, ALU_SLL, 32'h0000_0001, 32'd20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("async_rel");
    run(0, ALU_ROR, 32'h0000_0001, 32'd4, 32'h1000_0000, 5, 1'b0, "recover");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_shift_seq.md
# alu_shift_seq

Iterative, multi-cycle shift/rotate execution unit that accepts one ALU shift request under a valid/ready handshake and returns the result under a second valid/ready handshake. It consumes the same operator encoding and operand format that the cv32e40p ALU shift path consumes. It sits beside the ALU in EX as the low-area alternative shift engine, and it is the result-producing counterpart to the shift stimulus our ALU benches drive. The unit processes `STEP` bit positions per cycle.

## Interface
Parameters:
- `STEP`, default 1: bit positions shifted per iteration. Legal values are 1, 2, 4, 8, 16.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `flush_i`: input, 1 bit. Synchronous abort of any in-flight request.
- `valid_i`: input, 1 bit. Request valid.
- `ready_o`: output, 1 bit. Unit can accept a request.
- `operator_i`: input, `alu_opcode_e`. Requested operation.
- `operand_a_i`: input, 32 bits. Value to shift.
- `operand_b_i`: input, 32 bits. Shift amount; only `[4:0]` is used.
- `valid_o`: output, 1 bit. Result valid.
- `ex_ready_i`: input, 1 bit. Downstream accepts the result.
- `result_o`: output, 32 bits. Shift result.
- `illegal_o`: output, 1 bit. Accompanies `valid_o`; the operator was not a shift.
- `busy_o`: output, 1 bit. High in the SHIFT and DONE states.

## Operation
- Supported operators: `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_ROR`.
- The shift amount is `amt = operand_b_i[4:0]`. Bits `[31:5]` are ignored, so 0x25 is treated as 5.
- Fill rules:
  - SLL fills with zeros from the LSB side.
  - SRL fills with zeros from the MSB side.
  - SRA replicates the original bit 31.
  - ROR moves the low bits into the MSB side.
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `ready_o` = 1.
  - When `valid_i` is high, the unit latches the operator, operand A and `amt` into the counter.
  - Next state is DONE if `amt` = 0 or the operator is unsupported; otherwise SHIFT.
  - An unsupported operator produces result = operand A with `illegal_o` = 1.
- **SHIFT**
  - Each cycle the data register shifts by `s = min(STEP, cnt)` and the counter decrements by `s`.
  - When `cnt` ≤ `STEP`, the final step is performed and the next state is DONE.
- **DONE**
  - `valid_o` = 1. `result_o` and `illegal_o` are held stable.
  - When `ex_ready_i` is high, next state is IDLE.
  - Before `ex_ready_i` arrives, `result_o` must not change and `valid_o` must not drop.
- **`flush_i`**
  - In any state, `flush_i` sends the next state to IDLE.
  - The request in flight is discarded and no `valid_o` is produced for it.
  - `flush_i` takes priority over `valid_i` and `ex_ready_i` in the same cycle.
  - A `valid_i` that arrives together with `flush_i` is not accepted.
- The unit holds one request at a time. `ready_o` is 0 in SHIFT and DONE, and a result handshake does not overlap with the next request.

## Timing
- Reset values:
  - state = IDLE.
  - `ready_o` = 1.
  - `valid_o`, `illegal_o`, `busy_o` = 0.
  - `result_o` = 0; the data register and counter are cleared.
- Reset asserted mid-operation returns the unit to IDLE immediately (asynchronously). No result is produced for the request in flight.
- Latency: a request accepted in cycle T has `valid_o` high from cycle T+1+ceil(`amt`/`STEP`).
  - `amt` = 0 or an illegal operator gives `valid_o` at T+1.
  - With `STEP` = 1 and `amt` = 31, `valid_o` is at T+32.
- Throughput: at most one request every 2+ceil(`amt`/`STEP`) cycles with `ex_ready_i` held high. The next `ready_o` comes in the cycle after the result handshake.
- `ready_o`, `valid_o` and `busy_o` are decoded from registered state only, with no combinational path from any input.

## Structure
- `alu_opcode_e` comes from `cv32e40p_pkg`.
- Add `alu_shift_seq_state_e` (IDLE, SHIFT, DONE) to `cv32e40p_pkg` alongside the other EX FSM enums.
- Add the constant `SHIFT_AMT_W = 5` to `cv32e40p_pkg`.
- One sub-module: `alu_shift_step`, purely combinational. It takes (operator, data, `s`, saved sign bit) and returns the data shifted by `s` ≤ `STEP`.

## Test plan
- SRA, a=0x80000004, b=1, `STEP`=1 → `result_o`=0xC0000002, `valid_o` at T+2, `illegal_o`=0.
- SRL, a=4, b=1 → 0x00000002. ROR, a=5, b=1 → 0x80000002. SLL, a=5, b=2 → 0x00000014 at T+3.
- b=0 → result equals a at T+1. b=0x25 → treated as 5: SLL, a=1 → 0x20. `STEP`=4, SRL, a=0xFFFFFFFF, b=31 → 0x1 at T+1+8.
- Backpressure: hold `ex_ready_i`=0 for 5 cycles in DONE → `result_o` and `valid_o` stable, `ready_o`=0. Release → IDLE next cycle, `ready_o`=1.
- `flush_i` on the 3rd SHIFT cycle of SLL, b=10 → no `valid_o` ever appears. A new request on the next cycle completes correctly.
- `rst_n` low mid-SHIFT → all outputs at reset values immediately. Unsupported operator (`ALU_ADD`) → `valid_o` at T+1, `illegal_o`=1, `result_o`=a.
